// File: rtl/operand_fetch_pipe.sv
// Operand-fetch stage: two 2R/1W register banks (int/float), valid/ready output register,
// load-use stall, write-back bypass; EX-result forwarding enabled by defining OPF_FWD_EN.
module operand_fetch_pipe #(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int CTRL_W         = 24,
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      AorF,
  input  logic                      RegWrite,
  input  logic                      MemRead,
  input  logic [REG_ADDR_W-1:0]     rs,
  input  logic [REG_ADDR_W-1:0]     rt,
  input  logic [REG_ADDR_W-1:0]     wdst,
  input  logic [CTRL_W-1:0]         ctrl,
  input  logic [15:0]               immediate,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic                      wb_en,
  input  logic                      wb_AorF,
  input  logic [REG_ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      fwd_en,
  input  logic                      fwd_AorF,
  input  logic [REG_ADDR_W-1:0]     fwd_addr,
  input  logic [DATA_W-1:0]         fwd_data,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         op1,
  output logic [DATA_W-1:0]         op2,
  output logic                      AorF_next,
  output logic                      RegWrite_next,
  output logic                      MemRead_next,
  output logic [REG_ADDR_W-1:0]     wdst_next,
  output logic [REG_ADDR_W-1:0]     rt_next,
  output logic [CTRL_W-1:0]         ctrl_next,
  output logic [15:0]               immediate_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] r_bank_int [NREG];
  logic [DATA_W-1:0] r_bank_flt [NREG];

  logic                      r_out_valid;
  logic [DATA_W-1:0]         r_op1;
  logic [DATA_W-1:0]         r_op2;
  logic                      r_aorf;
  logic                      r_regwrite;
  logic                      r_memread;
  logic [REG_ADDR_W-1:0]     r_wdst;
  logic [REG_ADDR_W-1:0]     r_rt;
  logic [CTRL_W-1:0]         r_ctrl;
  logic [15:0]               r_imm;
  logic [INST_MEM_WIDTH-1:0] r_pc;

  logic w_advance;
  logic w_hazard;
  logic w_accept;
  logic w_wdst_hit;
  logic w_wdst_is_r0;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

`ifndef OPF_FWD_EN
  logic w_fwd_unused;
  assign w_fwd_unused = ^{fwd_en, fwd_AorF, fwd_addr, fwd_data};
`endif

  // Int r0 is hard-wired to zero, so writes to it are simply dropped.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_bank_int[i] <= '0;
        r_bank_flt[i] <= '0;
      end
    end else if (wb_en) begin
      if (wb_AorF)
        r_bank_flt[wb_addr] <= wb_data;
      else if (wb_addr != '0)
        r_bank_int[wb_addr] <= wb_data;
    end
  end

  // One read port per source operand; port 0 serves rs, port 1 serves rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [REG_ADDR_W-1:0] w_idx;
      logic [DATA_W-1:0]     w_val;

      if (gi == 0) begin : g_rs
        assign w_idx = rs;
      end else begin : g_rt
        assign w_idx = rt;
      end

      always_comb begin
        w_val = AorF ? r_bank_flt[w_idx] : r_bank_int[w_idx];
        if (wb_en && (wb_AorF == AorF) && (wb_addr == w_idx))
          w_val = wb_data;
`ifdef OPF_FWD_EN
        if (fwd_en && (fwd_AorF == AorF) && (fwd_addr == w_idx))
          w_val = fwd_data;
`endif
        if (!AorF && (w_idx == '0))
          w_val = '0;
      end
    end
  endgenerate

  assign w_op1 = g_port[0].w_val;
  assign w_op2 = g_port[1].w_val;

  // A load still sitting in the output register cannot feed a dependent instruction yet.
  assign w_wdst_hit   = (r_wdst == rs) || (r_wdst == rt);
  assign w_wdst_is_r0 = !r_aorf && (r_wdst == '0);
  assign w_hazard     = r_out_valid && r_memread && r_regwrite &&
                        (r_aorf == AorF) && w_wdst_hit && !w_wdst_is_r0;

  assign w_advance = out_ready || !r_out_valid;
  assign in_ready  = w_advance && !w_hazard && !flush;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_aorf      <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_wdst      <= '0;
      r_rt        <= '0;
      r_ctrl      <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_op1      <= w_op1;
        r_op2      <= w_op2;
        r_aorf     <= AorF;
        r_regwrite <= RegWrite;
        r_memread  <= MemRead;
        r_wdst     <= wdst;
        r_rt       <= rt;
        r_ctrl     <= ctrl;
        r_imm      <= immediate;
        r_pc       <= pc;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign op1            = r_op1;
  assign op2            = r_op2;
  assign AorF_next      = r_aorf;
  assign RegWrite_next  = r_regwrite;
  assign MemRead_next   = r_memread;
  assign wdst_next      = r_wdst;
  assign rt_next        = r_rt;
  assign ctrl_next      = r_ctrl;
  assign immediate_next = r_imm;
  assign pc_next        = r_pc;

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Bench for operand_fetch_pipe: directed scenarios then randomized traffic against a behavioural model.
module tb_operand_fetch_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 24;
  localparam int PW = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset, in_valid, in_ready, AorF, RegWrite, MemRead;
  logic [AW-1:0] rs, rt, wdst, wb_addr, fwd_addr;
  logic [CW-1:0] ctrl;
  logic [15:0]   immediate;
  logic [PW-1:0] pc;
  logic wb_en, wb_AorF, fwd_en, fwd_AorF, flush, out_ready, out_valid;
  logic [DW-1:0] wb_data, fwd_data, op1, op2;
  logic AorF_next, RegWrite_next, MemRead_next;
  logic [AW-1:0] wdst_next, rt_next;
  logic [CW-1:0] ctrl_next;
  logic [15:0]   immediate_next;
  logic [PW-1:0] pc_next;

  operand_fetch_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .INST_MEM_WIDTH(PW)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .AorF(AorF), .RegWrite(RegWrite), .MemRead(MemRead),
    .rs(rs), .rt(rt), .wdst(wdst), .ctrl(ctrl), .immediate(immediate), .pc(pc),
    .wb_en(wb_en), .wb_AorF(wb_AorF), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_en(fwd_en), .fwd_AorF(fwd_AorF), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .op1(op1), .op2(op2), .AorF_next(AorF_next), .RegWrite_next(RegWrite_next),
    .MemRead_next(MemRead_next), .wdst_next(wdst_next), .rt_next(rt_next),
    .ctrl_next(ctrl_next), .immediate_next(immediate_next), .pc_next(pc_next)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: register contents plus the expected output record.
  logic [DW-1:0] mem [2][32];
  logic          m_valid, m_aorf, m_rw, m_mr;
  logic [DW-1:0] m_op1, m_op2;
  logic [AW-1:0] m_wdst, m_rt;
  logic [CW-1:0] m_ctrl;
  logic [15:0]   m_imm;
  logic [PW-1:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic bank, input logic [AW-1:0] idx);
    if (!bank && idx == 0) return '0;
`ifdef OPF_FWD_EN
    if (fwd_en && fwd_AorF == bank && fwd_addr == idx) return fwd_data;
`endif
    if (wb_en && wb_AorF == bank && wb_addr == idx) return wb_data;
    return mem[bank][idx];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".op1"}, 64'(op1), 64'(m_op1));
    chk({tag, ".op2"}, 64'(op2), 64'(m_op2));
    chk({tag, ".AorF_next"}, 64'(AorF_next), 64'(m_aorf));
    chk({tag, ".RegWrite_next"}, 64'(RegWrite_next), 64'(m_rw));
    chk({tag, ".MemRead_next"}, 64'(MemRead_next), 64'(m_mr));
    chk({tag, ".wdst_next"}, 64'(wdst_next), 64'(m_wdst));
    chk({tag, ".rt_next"}, 64'(rt_next), 64'(m_rt));
    chk({tag, ".ctrl_next"}, 64'(ctrl_next), 64'(m_ctrl));
    chk({tag, ".immediate_next"}, 64'(immediate_next), 64'(m_imm));
    chk({tag, ".pc_next"}, 64'(pc_next), 64'(m_pc));
  endtask

  // Inputs are already applied; check in_ready, advance the model, clock, check outputs.
  task automatic cycle(input string tag);
    logic adv, haz, rdy, acc;
    logic [DW-1:0] a, b;
    adv = out_ready || !m_valid;
    haz = m_valid && m_mr && m_rw && (m_aorf == AorF) &&
          (m_wdst == rs || m_wdst == rt) && !(m_aorf == 1'b0 && m_wdst == 0);
    rdy = adv && !haz && !flush;
    acc = in_valid && rdy;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    a = ref_read(AorF, rs);
    b = ref_read(AorF, rt);
    if (flush) m_valid = 1'b0;
    else if (adv) begin
      m_valid = acc;
      if (acc) begin
        m_op1 = a; m_op2 = b; m_aorf = AorF; m_rw = RegWrite; m_mr = MemRead;
        m_wdst = wdst; m_rt = rt; m_ctrl = ctrl; m_imm = immediate; m_pc = pc;
      end
    end
    if (wb_en && !(wb_AorF == 1'b0 && wb_addr == 0)) mem[wb_AorF][wb_addr] = wb_data;
    if (acc)
      $display("txn %s bank=%0d rs=%0d rt=%0d op1=%h op2=%h", tag, AorF, rs, rt, a, b);
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    in_valid = 0; AorF = 0; RegWrite = 0; MemRead = 0; rs = 0; rt = 0; wdst = 0;
    ctrl = 0; immediate = 0; pc = 0; wb_en = 0; wb_AorF = 0; wb_addr = 0; wb_data = 0;
    fwd_en = 0; fwd_AorF = 0; fwd_addr = 0; fwd_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic inst(input logic bank, input logic rw, input logic mr,
                      input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d);
    in_valid = 1; AorF = bank; RegWrite = rw; MemRead = mr; rs = s; rt = t; wdst = d;
    ctrl = CW'($urandom); immediate = 16'($urandom); pc = PW'($urandom);
  endtask

  logic [DW-1:0] s_op1, s_op2;
  logic [CW-1:0] s_ctrl;

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge CLK);
    #1;
    reset = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) mem[b][i] = '0;
    m_valid = 0; m_aorf = 0; m_rw = 0; m_mr = 0; m_op1 = 0; m_op2 = 0;
    m_wdst = 0; m_rt = 0; m_ctrl = 0; m_imm = 0; m_pc = 0;
    check_outputs("reset");

    // 1: write r3, then read rs=3 / rt=0
    idle(); wb_en = 1; wb_addr = 3; wb_data = 32'h1234;
    cycle("t1_wb");
    idle(); inst(0, 0, 0, 3, 0, 1);
    cycle("t1_rd");
    chk("t1_op1", 64'(op1), 64'h1234);
    chk("t1_op2", 64'(op2), 64'h0);

    // 2: write-through on the accept cycle
    idle(); inst(0, 0, 0, 5, 3, 2); wb_en = 1; wb_addr = 5; wb_data = 32'hDEAD;
    cycle("t2");
    chk("t2_op1", 64'(op1), 64'hDEAD);

    // 3: load-use inserts one bubble
    idle(); inst(0, 1, 1, 1, 2, 7);
    cycle("t3_load");
    idle(); inst(0, 0, 0, 7, 0, 4);
    cycle("t3_haz");
    chk("t3_bubble", 64'(out_valid), 64'h0);
    cycle("t3_go");
    chk("t3_accept", 64'(out_valid), 64'h1);

    // 4: back-pressure holds the output
    idle(); inst(0, 0, 0, 3, 5, 6);
    cycle("t4_a");
    s_op1 = op1; s_op2 = op2; s_ctrl = ctrl_next;
    idle(); inst(0, 0, 0, 5, 3, 8); out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle("t4_stall");
      chk("t4_op1_hold", 64'(op1), 64'(s_op1));
      chk("t4_op2_hold", 64'(op2), 64'(s_op2));
      chk("t4_ctrl_hold", 64'(ctrl_next), 64'(s_ctrl));
    end
    out_ready = 1;
    cycle("t4_release");
    chk("t4_new_op1", 64'(op1), 64'hDEAD);

    // 5: flush kills input; float f2 write still lands
    idle(); inst(0, 0, 0, 3, 3, 1); flush = 1;
    wb_en = 1; wb_AorF = 1; wb_addr = 2; wb_data = 32'hF00D;
    cycle("t5_flush");
    chk("t5_killed", 64'(out_valid), 64'h0);
    idle(); inst(1, 0, 0, 2, 0, 0);
    cycle("t5_rd");
    chk("t5_f2", 64'(op1), 64'hF00D);

    // 6: forward vs write-back on the same register
    idle(); inst(0, 0, 0, 4, 0, 1);
    fwd_en = 1; fwd_addr = 4; fwd_data = 32'h55;
    wb_en = 1; wb_addr = 4; wb_data = 32'h66;
    cycle("t6");
`ifdef OPF_FWD_EN
    chk("t6_op1", 64'(op1), 64'h55);
`else
    chk("t6_op1", 64'(op1), 64'h66);
`endif

    // randomized traffic over a small register window to provoke bypass and hazards
    for (int n = 0; n < 400; n++) begin
      idle();
      in_valid = ($urandom_range(0, 3) != 0);
      inst(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      in_valid = ($urandom_range(0, 3) != 0);
      wb_en = 1'($urandom); wb_AorF = 1'($urandom);
      wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      fwd_en = 1'($urandom); fwd_AorF = 1'($urandom);
      fwd_addr = AW'($urandom_range(0, 7)); fwd_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
